spi_controller: RTL
===================

Name: spi_controller

Overview:
SPI mode-0 initiator that issues single 16-bit register-access frames to the project's SPI peripheral (register file behind ui_in nCS/SCLK/COPI pins). The bench and future top-level integration use it to program the PWM/output-enable registers. Frame format, MSB first: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data. A host-side start/busy/done handshake launches a frame. For reads, CIPO data is captured and returned.

Parameters:
CLK_DIV, 2, clk cycles per SCLK half-period (>=1); SCLK = clk/(2*CLK_DIV)
CS_GAP, 4, minimum clk cycles nCS stays high after a frame before done (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  launch request; sampled only in IDLE
rw  input  1  1 = write, 0 = read; latched at start
addr  input  7  register address; latched at start
wdata  input  8  write data; latched at start (sent as-is on reads)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at end of frame
rdata  output  8  read data; updated only at done of a read frame
sclk  output  1  SPI clock, idle low
ncs  output  1  chip select, active low, idle high
copi  output  1  controller-out data
cipo  input  1  peripheral-out data

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset (rst=1 at a clk edge): state IDLE; ncs=1, sclk=0, copi=0, busy=0, done=0, rdata=0. Takes priority over everything; a frame in progress is aborted. ncs rises and sclk falls at that edge, and no done is issued.
- States: IDLE, LEAD, SHIFT, TRAIL, GAP. Outputs are registered.
- IDLE: when start=1 at edge E0, latch shreg={rw,addr,wdata}. After E0: ncs=0, copi=shreg[15], busy=1, enter LEAD. start while busy is ignored.
- LEAD: CLK_DIV cycles; then sclk=1 (rising edge 1) and enter SHIFT.
- SHIFT: sclk toggles every CLK_DIV cycles.
  - Each rising edge: shift cipo into a 16-bit rx register.
  - Each falling edge except the 16th: present the next shreg bit on copi.
  - copi changes only on falling edges, so it is stable for the full sclk-high time.
  - After the 16th falling edge, enter TRAIL.
- TRAIL: CLK_DIV cycles with ncs=0 and sclk=0; then ncs=1, copi=0, enter GAP.
- GAP: CS_GAP cycles; then done=1 for one cycle, busy=0, IDLE. If the frame was a read, rdata=rx[7:0] at the same edge; on writes, rdata holds.
- Timing relative to E0:
  - First sclk rise at E0+CLK_DIV.
  - Last sclk fall at E0+32*CLK_DIV.
  - ncs high at E0+33*CLK_DIV.
  - done/busy-low at E0+33*CLK_DIV+CS_GAP.
- start=1 in the done cycle is accepted (state is IDLE), giving back-to-back frames with ncs high for at least CS_GAP+1 cycles.
- Input changes after E0 have no effect on the current frame.
- Counters: half-period counter sized for CLK_DIV; bit counter 0..16, 5 bits; no wrap beyond 16.

Test Plan:
- Reset: hold rst 3 cycles -> ncs=1, sclk=0, copi=0, busy=0, done=0, rdata=0x00; no sclk activity over 100 idle cycles.
- Write (CLK_DIV=2, CS_GAP=4): rw=1, addr=0x02, wdata=0xA5 -> bench mode-0 monitor decodes 0x82A5 with exactly 16 rising sclk; ncs high 66 cycles after E0; done pulse 70 cycles after E0; rdata unchanged.
- Read: rw=0, addr=0x05; bench responder drives 0x3C on cipo during data bits (changing on falling sclk) -> copi frame 0x05xx, rdata=0x3C at done, busy low.
- Start while busy: pulse start again at E0+10 with different addr -> exactly one frame (original addr), one done pulse.
- Reset mid-frame: assert rst after 5th sclk rise -> next edge ncs=1, sclk=0, busy=0, no done; a subsequent write 0x80FF transmits correctly.
- Back-to-back plus integration: start held high across done; writes 0x00<-0xFF then 0x04<-0x80 into the tt_um SPI peripheral -> peripheral registers read back 0xFF and 0x80; ncs high gap >= 5 cycles between frames.

Source files
------------

// File: rtl/spi_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_controller_if
//  Description : Host handshake and SPI pin bundle for spi_controller.
//                The master modport is the controller's view; slave is the
//                view of the host and peripheral surrounding it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_controller_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       sclk;
  logic       ncs;
  logic       copi;
  logic       cipo;

  modport master (
    input  start, rw, addr, wdata, cipo,
    output busy, done, rdata, sclk, ncs, copi
  );

  modport slave (
    output start, rw, addr, wdata, cipo,
    input  busy, done, rdata, sclk, ncs, copi
  );
endinterface
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : spi_controller
//  Description : SPI mode-0 initiator issuing one 16-bit register frame
//                {rw, addr[6:0], data[7:0]} MSB first per start request.
//                Read frames return the last 8 bits seen on cipo.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_controller #(
  parameter int CLK_DIV = 2,  // clk cycles per SCLK half-period
  parameter int CS_GAP  = 4   // clk cycles ncs stays high before done
) (
  input  wire logic         clk,
  input  wire logic         rst,
  spi_controller_if.master  spi
);

  // One counter serves both the half-period timing and the post-frame gap,
  // so it is wide enough for the larger of the two.
  localparam int              c_CNT_MAX   = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int              c_CW        = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
  localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLK_DIV - 1);
  localparam logic [c_CW-1:0] c_GAP_LAST  = c_CW'(CS_GAP - 1);
  localparam logic [4:0]      c_LAST_BIT  = 5'd15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TRAIL = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [c_CW-1:0] cnt_q, cnt_d;
  logic [4:0]      bits_q, bits_d;    // falling sclk edges seen, 0..16
  logic [15:0]     shreg_q, shreg_d;  // bit 15 drives copi directly
  logic [7:0]      rx_q, rx_d;        // only the data byte is ever returned
  logic            rw_q, rw_d;
  logic            sclk_q, sclk_d;
  logic            ncs_q, ncs_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      rdata_q, rdata_d;

  logic            w_half_tick;
  assign w_half_tick = (cnt_q == c_HALF_LAST);

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (spi.start) begin
          shreg_d = {spi.rw, spi.addr, spi.wdata};
          rw_d    = spi.rw;
          bits_d  = '0;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        // End of lead-in is the first rising sclk edge: sample cipo here too.
        if (w_half_tick) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], spi.cipo};
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_half_tick) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], spi.cipo};
          end else begin
            sclk_d = 1'b0;
            bits_d = bits_q + 5'd1;
            if (bits_q == c_LAST_BIT) begin
              state_d = S_TRAIL;
            end else begin
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end
        end
      end
      S_TRAIL: begin
        if (w_half_tick) begin
          cnt_d   = '0;
          ncs_d   = 1'b1;
          shreg_d = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == c_GAP_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (!rw_q) begin
            rdata_d = rx_q;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      rx_q    <= '0;
      rw_q    <= 1'b0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      rw_q    <= rw_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign spi.sclk  = sclk_q;
  assign spi.ncs   = ncs_q;
  assign spi.copi  = shreg_q[15];
  assign spi.busy  = busy_q;
  assign spi.done  = done_q;
  assign spi.rdata = rdata_q;

endmodule
`default_nettype wire
